// File: rtl/pll_lock_tick_gen.sv
// pll_lock_tick_gen
//   Qualifies the main PLL's asynchronous lock flag and holds the downstream modem
//   datapath in reset until the PLL has stayed locked for SETTLE_CYCLES consecutive
//   cycles. Once running, it divides the clock down to a one-cycle sample strobe and
//   reports the position within the current sample period.
//
// Parameters
//   SYNC_STAGES    lock-flag synchroniser depth (>= 2)
//   SETTLE_CYCLES  consecutive locked cycles required before RUN (>= 1)
//   TICK_DIV       clock cycles per sample_tick (>= 2)
//   PHASE_W        width of tick_phase (2**PHASE_W >= TICK_DIV)
//
// Ports
//   clock            in   PLL output clock, rising-edge logic
//   reset            in   synchronous, active-high
//   locked           in   PLL lock flag, asynchronous to clock
//   run_reset        out  synchronous active-high reset for downstream logic
//   sample_tick      out  one-cycle strobe every TICK_DIV cycles while in RUN
//   tick_phase       out  position within the sample period, 0..TICK_DIV-1
//   state            out  0=WAIT_LOCK 1=SETTLE 2=RUN
//   lock_loss_count  out  saturating count of RUN->WAIT_LOCK lock losses
//
// Build option
//   LOCK_LOSS_COUNT_EN  when defined, lock_loss_count counts lock losses out of RUN
//                       (saturating at 255); otherwise it is tied to zero.

module pll_lock_tick_gen #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 65536,
    parameter int unsigned TICK_DIV      = 8192,
    parameter int unsigned PHASE_W       = 13
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               locked,
    output logic               run_reset,
    output logic               sample_tick,
    output logic [PHASE_W-1:0] tick_phase,
    output logic [1:0]         state,
    output logic [7:0]         lock_loss_count
);

    // Keep the settle counter at least one bit wide when SETTLE_CYCLES == 1.
    localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PhaseLast  = PHASE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StSettle   = 2'd1,
        StRun      = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 locked_s;
    logic [SettleW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 run_reset_q, run_reset_d;
    logic                 tick_q, tick_d;

    // Raw lock flag is used nowhere except the first synchroniser flop.
    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    // Next-state logic; lock loss always wins over settle completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitLock: begin
                if (locked_s) state_d = StSettle;
            end
            StSettle: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                end else if (settle_cnt_q == SettleLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!locked_s) state_d = StWaitLock;
            end
            default: state_d = StWaitLock;
        endcase
    end

    // Datapath next values, all derived from the upcoming state so the outputs
    // change on the same edge as the state register.
    always_comb begin
        settle_cnt_d = '0;
        phase_d      = '0;
        run_reset_d  = (state_d != StRun);
        tick_d       = 1'b0;

        if (state_q == StSettle && state_d == StSettle) begin
            settle_cnt_d = settle_cnt_q + 1'b1;
        end

        // Phase only advances while staying in RUN; the entry edge leaves it at 0,
        // so the first tick lands TICK_DIV cycles after run_reset falls.
        if (state_q == StRun && state_d == StRun) begin
            if (phase_q == PhaseLast) begin
                phase_d = '0;
                tick_d  = 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StWaitLock;
            settle_cnt_q <= '0;
            phase_q      <= '0;
            run_reset_q  <= 1'b1;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            phase_q      <= phase_d;
            run_reset_q  <= run_reset_d;
            tick_q       <= tick_d;
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] loss_cnt_q;

    // Only losses out of RUN count; an aborted settle is not a lock loss.
    always_ff @(posedge clock) begin
        if (reset) begin
            loss_cnt_q <= 8'd0;
        end else if (state_q == StRun && !locked_s && loss_cnt_q != 8'hFF) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_count = loss_cnt_q;
`else
    assign lock_loss_count = 8'd0;
`endif

    assign run_reset   = run_reset_q;
    assign sample_tick = tick_q;
    assign tick_phase  = phase_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_tick_gen.sv
// Directed bench for pll_lock_tick_gen with a small configuration
// (SYNC_STAGES=2, SETTLE_CYCLES=16, TICK_DIV=8, PHASE_W=3). Inputs change 1 ns after
// a rising edge and outputs are sampled at the same point, so "after edge N" below
// means the value registered on edge N. Edge numbering in each section restarts at
// the first edge that sees the new locked value.

module tb_pll_lock_tick_gen;

    logic       clock;
    logic       reset;
    logic       locked;
    logic       run_reset;
    logic       sample_tick;
    logic [2:0] tick_phase;
    logic [1:0] state;
    logic [7:0] lock_loss_count;

    int checks = 0;
    int errors = 0;

`ifdef LOCK_LOSS_COUNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    pll_lock_tick_gen #(
        .SYNC_STAGES  (2),
        .SETTLE_CYCLES(16),
        .TICK_DIV     (8),
        .PHASE_W      (3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .locked         (locked),
        .run_reset      (run_reset),
        .sample_tick    (sample_tick),
        .tick_phase     (tick_phase),
        .state          (state),
        .lock_loss_count(lock_loss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return CntEn ? 32'(n) : 32'd0;
    endfunction

    initial begin
        reset  = 1'b1;
        locked = 1'b0;
        step(1);
        reset = 1'b0;
        check("rst_state", state, 0);
        check("rst_run_reset", run_reset, 1);
        check("rst_tick", sample_tick, 0);
        check("rst_phase", tick_phase, 0);
        check("rst_loss", lock_loss_count, 0);

        // 1. Unlocked for 100 cycles: parked in WAIT_LOCK.
        for (int i = 0; i < 100; i++) begin
            step(1);
            check("idle_state", state, 0);
            check("idle_run_reset", run_reset, 1);
            check("idle_tick", sample_tick, 0);
            check("idle_phase", tick_phase, 0);
        end

        // 2. Lock acquire: SETTLE after edge 3, RUN after edge 19, ticks at 27/35/43.
        locked = 1'b1;
        step(2);
        check("acq_e2_state", state, 0);
        step(1);
        check("acq_e3_state", state, 1);
        step(15);
        check("acq_e18_state", state, 1);
        check("acq_e18_run_reset", run_reset, 1);
        step(1);
        check("acq_e19_state", state, 2);
        check("acq_e19_run_reset", run_reset, 0);
        check("acq_e19_phase", tick_phase, 0);
        check("acq_e19_tick", sample_tick, 0);
        for (int e = 20; e <= 43; e++) begin
            step(1);
            check("run_phase", tick_phase, 32'((e - 19) % 8));
            check("run_tick", sample_tick, (e == 27 || e == 35 || e == 43) ? 1 : 0);
        end
        step(5);
        check("pre_drop_phase", tick_phase, 5);

        // 4. Drop lock at phase 5: still RUN for two edges, exit on the third
        //    with no tick even though phase 7 -> 0 would have been a wrap.
        locked = 1'b0;
        step(1);
        check("drop_e1_run_reset", run_reset, 0);
        check("drop_e1_phase", tick_phase, 6);
        step(1);
        check("drop_e2_run_reset", run_reset, 0);
        check("drop_e2_phase", tick_phase, 7);
        step(1);
        check("drop_e3_run_reset", run_reset, 1);
        check("drop_e3_state", state, 0);
        check("drop_e3_phase", tick_phase, 0);
        check("drop_e3_tick", sample_tick, 0);
        check("drop_loss", lock_loss_count, exp_cnt(1));

        locked = 1'b1;
        step(2);
        check("relock_e2_state", state, 0);
        step(1);
        check("relock_e3_state", state, 1);
        step(16);
        check("relock_e19_state", state, 2);
        check("relock_e19_run_reset", run_reset, 0);
        for (int e = 20; e <= 27; e++) begin
            step(1);
            check("relock_phase", tick_phase, 32'((e - 19) % 8));
            check("relock_tick", sample_tick, (e == 27) ? 1 : 0);
        end

        // 3. One-cycle lock glitch in SETTLE at settle_cnt=10 forces a full restart.
        locked = 1'b0;
        step(3);
        check("glitch_exit_state", state, 0);
        check("glitch_loss", lock_loss_count, exp_cnt(2));
        step(2);
        locked = 1'b1;
        step(11);
        check("glitch_e11_state", state, 1);
        locked = 1'b0;
        step(1);
        check("glitch_e12_state", state, 1);
        locked = 1'b1;
        step(1);
        check("glitch_e13_state", state, 1);
        step(1);
        check("glitch_e14_state", state, 0);
        check("glitch_e14_run_reset", run_reset, 1);
        step(1);
        check("glitch_e15_state", state, 1);
        for (int e = 16; e <= 30; e++) begin
            step(1);
            check("glitch_settle_state", state, 1);
            check("glitch_settle_run_reset", run_reset, 1);
        end
        step(1);
        check("glitch_e31_state", state, 2);
        check("glitch_e31_run_reset", run_reset, 0);
        check("glitch_settle_loss", lock_loss_count, exp_cnt(2));

        // 5. Reset in RUN with a tick due on the next edge.
        step(7);
        check("rst_run_phase", tick_phase, 7);
        check("rst_run_tick", sample_tick, 0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst_run_state", state, 0);
        check("rst_run_run_reset", run_reset, 1);
        check("rst_run_tick_after", sample_tick, 0);
        check("rst_run_phase_after", tick_phase, 0);
        check("rst_run_loss", lock_loss_count, 0);

        // 6. 300 lock losses out of RUN: counter saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            locked = 1'b1;
            step(19);
            check("sat_run_state", state, 2);
            locked = 1'b0;
            step(3);
            if (i == 1 || i == 254 || i == 255 || i == 300) begin
                check("sat_loss", lock_loss_count, exp_cnt((i > 255) ? 255 : i));
            end
        end
        step(10);
        check("sat_loss_hold", lock_loss_count, exp_cnt(255));
        check("sat_final_state", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
